// File: rtl/counter.sv
// ============================================================================
//  Module      : counter
//  Description : Parameterizable up-counter with a wrap or saturate policy at
//                MAX_COUNT and a registered terminal-count flag.
//                Optional macro COUNTER_EDGE_TRIG_EN makes the counter advance
//                once per rising edge of trigger instead of once per cycle
//                while trigger is high.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module counter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int WRAP      = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trigger,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic             advance;
  logic [WIDTH-1:0] next_count;

`ifdef COUNTER_EDGE_TRIG_EN
  logic trig_q;

  // Remember last cycle's trigger so a held-high trigger counts only once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trigger;
    end
  end

  assign advance = trigger & ~trig_q;
`else
  assign advance = trigger;
`endif

  // Next count: step by one below the terminal value, otherwise wrap or hold.
  // The explicit compare keeps MAX_COUNT < 2**WIDTH-1 working.
  always_comb begin
    next_count = count;
    if (advance) begin
      if (count == MAX_VAL) begin
        next_count = (WRAP != 0) ? ZERO : MAX_VAL;
      end else begin
        next_count = count + 1'b1;
      end
    end
  end

  // Count register and terminal flag; terminal is decoded from the next value
  // so it is high in exactly the cycles where count equals MAX_COUNT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      terminal <= 1'b0;
    end else begin
      count    <= next_count;
      terminal <= (next_count == MAX_VAL);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter.sv
// ============================================================================
//  Module      : tb_counter
//  Description : Self-checking bench for counter. Three instances cover
//                8-bit wrap at 255, 8-bit saturate at 20 and 4-bit wrap at 9.
//                Expectations follow COUNTER_EDGE_TRIG_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_counter;

`ifdef COUNTER_EDGE_TRIG_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset   = 1'b0;
  logic trigger = 1'b0;

  logic [7:0] count_a, count_b;
  logic [3:0] count_c;
  logic       term_a, term_b, term_c;

  always #5 clock = ~clock;

  counter #(.WIDTH(8), .MAX_COUNT(255), .WRAP(1)) dut_a (
    .clock(clock), .reset(reset), .trigger(trigger),
    .count(count_a), .terminal(term_a));

  counter #(.WIDTH(8), .MAX_COUNT(20), .WRAP(0)) dut_b (
    .clock(clock), .reset(reset), .trigger(trigger),
    .count(count_b), .terminal(term_b));

  counter #(.WIDTH(4), .MAX_COUNT(9), .WRAP(1)) dut_c (
    .clock(clock), .reset(reset), .trigger(trigger),
    .count(count_c), .terminal(term_c));

  int tests = 0;
  int fails = 0;

  // Reference model: plain integers per instance.
  int m_cnt [3];
  int m_max [3] = '{255, 20, 9};
  int m_wrap[3] = '{1, 0, 1};
  int m_prev;

  typedef struct {
    logic trig;
    int   exp_a;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_cnt(input int k);
    case (k)
      0:       return int'(count_a);
      1:       return int'(count_b);
      default: return int'(count_c);
    endcase
  endfunction

  function automatic int dut_term(input int k);
    case (k)
      0:       return int'(term_a);
      1:       return int'(term_b);
      default: return int'(term_c);
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s cnt%0d", tag, k), dut_cnt(k), m_cnt[k]);
      check($sformatf("%s term%0d", tag, k), dut_term(k),
            (m_cnt[k] == m_max[k]) ? 1 : 0);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_prev = 0;
  endtask

  // One rising edge of the reference: count rules straight from the
  // behavioural description.
  task automatic model_edge();
    int t;
    bit adv;
    if (reset === 1'b1) begin
      t      = (trigger === 1'b1) ? 1 : 0;
      adv    = (t == 1) && (!EDGE || m_prev == 0);
      m_prev = t;
      for (int k = 0; k < 3; k++) begin
        if (adv) begin
          if (m_cnt[k] == m_max[k]) m_cnt[k] = (m_wrap[k] != 0) ? 0 : m_max[k];
          else                      m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic cycle(input logic t, input string tag);
    trigger = t;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Assert reset in the middle of a cycle and check it clears without an edge.
  task automatic mid_reset(input string tag);
    @(posedge clock);
    #3;
    reset = 1'b0;
    model_clear();
    #1;
    check_all(tag);
  endtask

  task automatic release_reset();
    @(posedge clock);
    model_edge();
    #1;
    check_all("in_reset");
    reset = 1'b1;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 1};
    vecs[1] = '{1'b0, 1};
    vecs[2] = '{1'b0, 1};
    vecs[3] = '{1'b1, 2};
    vecs[4] = '{1'b1, EDGE ? 2 : 3};

    // Reset held with trigger toggling (including an unknown value).
    reset = 1'b0;
    model_clear();
    #1;
    check_all("reset_init");
    for (int i = 0; i < 20; i++) begin
      #10;
      if (i == 5) trigger = 1'bx;
      else        trigger = (i % 2 == 0) ? 1'b1 : 1'b0;
      check_all("reset_hold");
    end

    // Synchronous release just after an edge, then ramp 1..10.
    @(posedge clock);
    #1;
    trigger = 1'b0;
    reset   = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, "ramp");
      check("ramp_a_abs", int'(count_a), EDGE ? 1 : i);
    end
    for (int i = 11; i <= 256; i++) begin
      cycle(1'b1, "run");
      if (!EDGE && i == 255) begin
        check("a_at_max", int'(count_a), 255);
        check("a_term_at_max", int'(term_a), 1);
      end
    end
    check("a_after_256", int'(count_a), EDGE ? 1 : 0);
    check("a_term_after_256", int'(term_a), 0);
    check("b_saturated", int'(count_b), EDGE ? 1 : 20);
    check("b_term_sat", int'(term_b), EDGE ? 0 : 1);
    check("c_wrapped", int'(count_c), EDGE ? 1 : 6);

    // Table: trigger pattern from a fresh reset.
    mid_reset("async_clear");
    check("async_clear_a_abs", int'(count_a), 0);
    release_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].trig, "vec");
      check($sformatf("vec%0d_a", i), int'(count_a), vecs[i].exp_a);
    end
    mid_reset("mid_count_clear");
    check("mid_count_clear_abs", int'(count_a), 0);
    release_reset();
    cycle(1'b1, "restart");
    check("restart_a", int'(count_a), 1);

    // Pulse train: high 5, low 2, high 3.
    mid_reset("pulse_clear");
    trigger = 1'b0;
    release_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, "pulse_hi1");
    for (int i = 0; i < 2; i++) cycle(1'b0, "pulse_lo");
    for (int i = 0; i < 3; i++) cycle(1'b1, "pulse_hi2");
    check("pulse_total", int'(count_a), EDGE ? 2 : 8);

    // Randomized run with occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        mid_reset("rand_reset");
        trigger = 1'($urandom_range(0, 1));
        release_reset();
      end else begin
        cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire
